ahb_top: RTL and testbench

AHB_TOP -- requirements
Module: ahb_top

---
 rtl/ahb_top.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ahb_top.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_top.sv
// AHB-Lite slave: 16-word register file (region 00) plus timer/watchdog/PWM block (region 01).
// Latency: zero wait states for OKAY transfers; an ERROR takes two cycles (HREADY low, then high).
// Backpressure: HREADY is dropped only in the first ERROR cycle. Optional macro: AHB_TOP_PWM_EN.
module ahb_top #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  pwm,
  output logic                  wd_rst
);

  localparam int OFF_W = ADDR_WIDTH - 2;
  localparam int IDX_W = (REG_FILE_DEPTH > 1) ? $clog2(REG_FILE_DEPTH) : 1;
  localparam logic [OFF_W-1:0]      DEPTH_L     = OFF_W'(REG_FILE_DEPTH);
  localparam logic [DATA_WIDTH-1:0] WD_LOAD_RST = DATA_WIDTH'(64);

  // Timer register select codes (word offset HADDR[4:2])
  localparam logic [2:0] T_CTRL = 3'd0;
  localparam logic [2:0] T_CMP  = 3'd1;
  localparam logic [2:0] T_DUTY = 3'd2;
  localparam logic [2:0] T_WDL  = 3'd3;
  localparam logic [2:0] T_CNT  = 3'd4;
  localparam logic [2:0] T_STAT = 3'd5;

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} resp_state_t;

  // Reset synchroniser
  logic [1:0] r_rst_sync;
  logic       w_sync_rst;

  // Bus pipeline state
  resp_state_t           r_state;
  logic                  r_hready;
  logic                  r_hresp;
  logic                  r_wr_vld;
  logic                  r_wr_mem;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [2:0]            r_wr_tsel;
  logic [1:0]            r_wr_size;
  logic                  r_rd_vld;
  logic                  r_rd_mem;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [2:0]            r_rd_tsel;

  // Storage
  logic [DATA_WIDTH-1:0] r_mem [REG_FILE_DEPTH];
  logic [2:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic [DATA_WIDTH-1:0] r_wd_load;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_wd_cnt;
  logic                  r_wd_rst;

  // Decode / datapath wires
  logic                  w_xfer;
  logic [1:0]            w_region;
  logic [OFF_W-1:0]      w_off;
  logic                  w_mem_sel;
  logic                  w_mem_hit;
  logic                  w_tmr_ok;
  logic [2:0]            w_tsel;
  logic                  w_err;
  logic                  w_status;
  logic [DATA_WIDTH-1:0] w_duty;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_val;
  logic [DATA_WIDTH-1:0] w_rd_treg;
  logic [DATA_WIDTH-1:0] w_wd_next;
  logic                  w_twr;
  logic                  w_unused;

  // Narrow writes only replace the low byte/halfword; the rest of the word is kept.
  function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                    input logic [DATA_WIDTH-1:0] new_v,
                                                    input logic [1:0]            size);
    case (size)
      2'd0:    f_merge = {old_v[DATA_WIDTH-1:8],  new_v[7:0]};
      2'd1:    f_merge = {old_v[DATA_WIDTH-1:16], new_v[15:0]};
      default: f_merge = new_v;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_treg(input logic [2:0]            sel,
                                                   input logic [DATA_WIDTH-1:0] ctrl,
                                                   input logic [DATA_WIDTH-1:0] cmp,
                                                   input logic [DATA_WIDTH-1:0] duty,
                                                   input logic [DATA_WIDTH-1:0] wdl,
                                                   input logic [DATA_WIDTH-1:0] cnt,
                                                   input logic [DATA_WIDTH-1:0] stat);
    case (sel)
      T_CTRL:  f_treg = ctrl;
      T_CMP:   f_treg = cmp;
      T_DUTY:  f_treg = duty;
      T_WDL:   f_treg = wdl;
      T_CNT:   f_treg = cnt;
      T_STAT:  f_treg = stat;
      default: f_treg = '0;
    endcase
  endfunction

  // Two-flop reset synchroniser: asserts immediately, releases two edges after HRESETn rises
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_sync_rst = r_rst_sync[1];

  // Address-phase decode
  assign w_xfer    = HTRANS[1] & r_hready;
  assign w_region  = HADDR[ADDR_WIDTH-1 -: 2];
  assign w_off     = HADDR[OFF_W-1:0];
  assign w_mem_sel = (w_region == 2'b00);
  assign w_mem_hit = w_mem_sel && (w_off < DEPTH_L);
  assign w_tsel    = w_off[4:2];
  assign w_tmr_ok  = (w_region == 2'b01) && (w_off[1:0] == 2'b00) &&
                     (w_off[OFF_W-1:5] == '0) && (w_tsel <= T_STAT);
  assign w_err     = (HSIZE > 3'd2) || !(w_mem_hit || w_tmr_ok);

  // Response FSM: samples the address phase while HREADY is high, runs the two-cycle ERROR
  always_ff @(posedge HCLK or negedge w_sync_rst) begin
    if (!w_sync_rst) begin
      r_state   <= S_OKAY;
      r_hready  <= 1'b1;
      r_hresp   <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_mem  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_tsel <= '0;
      r_wr_size <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_mem  <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_tsel <= '0;
    end else begin
      r_wr_vld <= 1'b0;
      case (r_state)
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          if (w_xfer && w_err) begin
            r_state  <= S_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= 1'b1;
            if (!HWRITE) r_rd_vld <= 1'b0;
          end else begin
            r_state  <= S_OKAY;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            if (w_xfer) begin
              if (HWRITE) begin
                r_wr_vld  <= 1'b1;
                r_wr_mem  <= w_mem_sel;
                r_wr_idx  <= w_off[IDX_W-1:0];
                r_wr_tsel <= w_tsel;
                r_wr_size <= HSIZE[1:0];
              end else begin
                r_rd_vld  <= 1'b1;
                r_rd_mem  <= w_mem_sel;
                r_rd_idx  <= w_off[IDX_W-1:0];
                r_rd_tsel <= w_tsel;
              end
            end
          end
        end
      endcase
    end
  end

  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

`ifdef AHB_TOP_PWM_EN
  logic [DATA_WIDTH-1:0] r_duty;

  // DUTY register
  always_ff @(posedge HCLK or negedge w_sync_rst) begin
    if (!w_sync_rst)                     r_duty <= '0;
    else if (w_twr && r_wr_tsel == T_DUTY) r_duty <= w_wr_val;
  end
  assign w_duty   = r_duty;
  assign pwm      = r_ctrl[0] & r_ctrl[2] & (r_count < r_duty);
  assign w_unused = ^{HBURST, HPROT};
`else
  assign w_duty   = '0;
  assign pwm      = 1'b0;
  assign w_unused = ^{HBURST, HPROT, r_ctrl[2]};
`endif

  assign w_status  = (r_count == r_cmp);
  assign w_twr     = r_wr_vld & ~r_wr_mem;
  assign w_wd_next = r_wd_cnt + DATA_WIDTH'(1);

  // Old value of the write target, so narrow writes can keep the upper lanes
  always_comb begin
    w_wr_old = '0;
    if (r_wr_mem) w_wr_old = r_mem[r_wr_idx];
    else          w_wr_old = f_treg(r_wr_tsel, DATA_WIDTH'(r_ctrl), r_cmp, w_duty, r_wd_load,
                                    r_count, DATA_WIDTH'(w_status));
  end
  assign w_wr_val = f_merge(w_wr_old, HWDATA, r_wr_size);

  // Register file: written at the edge that ends the data phase
  always_ff @(posedge HCLK or negedge w_sync_rst) begin
    if (!w_sync_rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) r_mem[i] <= '0;
    end else if (r_wr_vld && r_wr_mem) begin
      r_mem[r_wr_idx] <= w_wr_val;
    end
  end

  // Timer, watchdog and their bus-writable control registers
  always_ff @(posedge HCLK or negedge w_sync_rst) begin
    if (!w_sync_rst) begin
      r_ctrl    <= '0;
      r_cmp     <= '0;
      r_wd_load <= WD_LOAD_RST;
      r_count   <= '0;
      r_wd_cnt  <= '0;
      r_wd_rst  <= 1'b0;
    end else begin
      if (r_ctrl[0]) r_count <= w_status ? '0 : r_count + DATA_WIDTH'(1);
      if (r_ctrl[1] && !r_wd_rst) begin
        r_wd_cnt <= w_wd_next;
        if (w_wd_next == r_wd_load) r_wd_rst <= 1'b1;
      end
      if (w_twr) begin
        case (r_wr_tsel)
          T_CTRL: r_ctrl <= w_wr_val[2:0];
          T_CMP:  r_cmp  <= w_wr_val;
          T_WDL: begin
            r_wd_load <= w_wr_val;
            r_wd_cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign wd_rst = r_wd_rst;

  // Read data follows the latched read address live until the next read
  always_comb begin
    w_rd_treg = f_treg(r_rd_tsel, DATA_WIDTH'(r_ctrl), r_cmp, w_duty, r_wd_load,
                       r_count, DATA_WIDTH'(w_status));
    HRDATA = '0;
    if (r_rd_vld) HRDATA = r_rd_mem ? r_mem[r_rd_idx] : w_rd_treg;
  end

endmodule

// File: tb/tb_ahb_top.sv
// Directed bench for ahb_top: register file, ERROR responses, timer, PWM and watchdog.
module tb_ahb_top;
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  BUSY   = 2'b01;
  localparam logic [1:0]  NONSEQ = 2'b10;
  localparam logic [1:0]  SEQ    = 2'b11;
  localparam logic [31:0] TBASE  = 32'h4000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = IDLE;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = 3'd0;
  logic [3:0]  HPROT = 4'd0;
  logic [31:0] HWDATA = '0;
  logic        HREADY, HRESP, pwm, wd_rst;
  logic [31:0] HRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_top dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .pwm(pwm), .wd_rst(wd_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // HREADY/HRESP packed as {HREADY,HRESP}: 2 = OKAY ready, 1 = ERROR cycle 1, 3 = ERROR cycle 2
  task automatic chk_resp(input string tag, input logic [31:0] exp);
    chk(tag, {30'd0, HREADY, HRESP}, exp);
  endtask

  // One bus cycle: drive the address phase and the data for the current data phase
  task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
    HTRANS = t; HWRITE = w; HADDR = a; HSIZE = s; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] s);
    drive(NONSEQ, 1'b1, a, s, 32'h0);
    chk_resp(tag, 32'd2);
    drive(IDLE, 1'b0, 32'h0, 3'd2, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    drive(NONSEQ, 1'b0, a, 3'd2, 32'h0);
    d = HRDATA;
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic err_xfer(input string tag, input logic w, input logic [31:0] a,
                          input logic [2:0] s, input logic [31:0] d);
    drive(NONSEQ, w, a, s, 32'h0);
    chk_resp({tag, "_c1"}, 32'd1);
    drive(IDLE, 1'b0, 32'h0, 3'd2, d);
    chk_resp({tag, "_c2"}, 32'd3);
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    chk_resp({tag, "_end"}, 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, a0, b0;
    logic [31:0] idx_t [8];
    logic [31:0] exp_t [8];
    logic [31:0] cnt_s [12];
    logic        st_s  [12];
    int ones, first, errs, highs;

    // ---- reset ----
    repeat (3) @(posedge HCLK);
    #1;
    chk_resp("rst_resp", 32'd2);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_pwm", {31'd0, pwm}, 32'd0);
    chk("rst_wdrst", {31'd0, wd_rst}, 32'd0);
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;

    // ---- register file basic write and out-of-range ERROR ----
    wr("w_mem0", 32'h0, 32'h0A, 3'd2);
    err_xfer("err_idx32", 1'b1, 32'h20, 3'd2, 32'h0B);
    rd(32'h0, v); chk("mem0_after_err", v, 32'h0A);
    err_xfer("err_idx16", 1'b0, 32'h10, 3'd2, 32'h0);

    // ---- NONSEQ write then BUSY/IDLE; read with following BUSY ----
    drive(NONSEQ, 1'b1, 32'h0F, 3'd2, 32'h0);
    drive(BUSY,   1'b0, 32'h00, 3'd2, 32'h04);
    chk_resp("busy_okay", 32'd2);
    drive(IDLE,   1'b0, 32'h00, 3'd2, 32'h0);
    drive(NONSEQ, 1'b0, 32'h0F, 3'd2, 32'h0);
    chk("rd15_dphase", HRDATA, 32'h04);
    drive(BUSY,   1'b0, 32'h00, 3'd2, 32'h0);
    chk("rd15_hold", HRDATA, 32'h04);
    drive(IDLE,   1'b0, 32'h00, 3'd2, 32'h0);

    // ---- back-to-back NONSEQ, then INCR4 burst ----
    drive(NONSEQ, 1'b1, 32'd1, 3'd2, 32'h0);  chk_resp("b2b_0", 32'd2);
    drive(NONSEQ, 1'b1, 32'd2, 3'd2, 32'h23); chk_resp("b2b_1", 32'd2);
    drive(NONSEQ, 1'b1, 32'd3, 3'd2, 32'h12); chk_resp("b2b_2", 32'd2);
    drive(NONSEQ, 1'b1, 32'd4, 3'd2, 32'h34); chk_resp("b2b_3", 32'd2);
    drive(IDLE,   1'b0, 32'd0, 3'd2, 32'h56); chk_resp("b2b_4", 32'd2);
    HBURST = 3'b011;
    drive(NONSEQ, 1'b1, 32'd0,  3'd2, 32'h0); chk_resp("incr4_0", 32'd2);
    drive(SEQ,    1'b1, 32'd4,  3'd2, 32'd1); chk_resp("incr4_1", 32'd2);
    drive(SEQ,    1'b1, 32'd8,  3'd2, 32'd2); chk_resp("incr4_2", 32'd2);
    drive(SEQ,    1'b1, 32'd12, 3'd2, 32'd3); chk_resp("incr4_3", 32'd2);
    drive(IDLE,   1'b0, 32'd0,  3'd2, 32'd4); chk_resp("incr4_4", 32'd2);
    HBURST = 3'b000;
    idx_t = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd12, 32'd15};
    exp_t = '{32'd1, 32'h23, 32'h12, 32'h34, 32'd2, 32'd3, 32'd4, 32'h04};
    for (int i = 0; i < 8; i++) begin
      rd(idx_t[i], v);
      chk($sformatf("mem%0d", idx_t[i]), v, exp_t[i]);
    end

    // ---- transfer sizes ----
    wr("w_word5", 32'd5, 32'hAABBCCDD, 3'd2);
    wr("w_byte5", 32'd5, 32'h11223344, 3'd0);
    rd(32'd5, v); chk("mem5_byte", v, 32'hAABBCC44);
    wr("w_half5", 32'd5, 32'h77665566, 3'd1);
    rd(32'd5, v); chk("mem5_half", v, 32'hAABB5566);
    err_xfer("err_size3", 1'b1, 32'd6, 3'd3, 32'hDEADBEEF);
    rd(32'd6, v); chk("mem6_unchanged", v, 32'h0);

    // ---- unmapped regions ----
    err_xfer("err_reg10", 1'b0, 32'h8000_0000, 3'd2, 32'h0);
    err_xfer("err_reg11", 1'b1, 32'hC000_0004, 3'd2, 32'h5);

    // ---- timer register map ----
    rd(TBASE + 32'h0C, v); chk("wdload_rst", v, 32'd64);
    rd(TBASE + 32'h10, v); chk("count_rst", v, 32'd0);
    rd(TBASE + 32'h14, v); chk("status_rst", v, 32'd1);
    wr("w_count_ro", TBASE + 32'h10, 32'h55, 3'd2);
    rd(TBASE + 32'h10, v); chk("count_ro", v, 32'd0);
    err_xfer("err_t18", 1'b0, TBASE + 32'h18, 3'd2, 32'h0);
    err_xfer("err_t02", 1'b1, TBASE + 32'h02, 3'd2, 32'h1);

    // ---- timer: COMPARE=5 gives a 6-cycle period ----
    wr("w_ctrl1", TBASE + 32'h00, 32'd1, 3'd2);
    wr("w_cmp5",  TBASE + 32'h04, 32'd5, 3'd2);
    rd(TBASE + 32'h04, v); chk("cmp_rb", v, 32'd5);
    drive(NONSEQ, 1'b0, TBASE + 32'h14, 3'd2, 32'h0);
    for (int i = 0; i < 12; i++) begin
      st_s[i] = HRDATA[0];
      drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    end
    ones = 0; first = 99;
    for (int i = 0; i < 12; i++) if (st_s[i]) begin
      ones++;
      if (first == 99) first = i;
    end
    chk("status_ones", ones, 32'd2);
    chk("status_period", {31'd0, (first < 6) && st_s[(first < 6) ? first + 6 : 0]}, 32'd1);
    drive(NONSEQ, 1'b0, TBASE + 32'h10, 3'd2, 32'h0);
    for (int i = 0; i < 12; i++) begin
      cnt_s[i] = HRDATA;
      drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    end
    errs = 0;
    for (int i = 0; i < 12; i++) if (cnt_s[i] != (cnt_s[0] + 32'(i)) % 32'd6) errs++;
    chk("count_seq", errs, 32'd0);
    chk("count_range", {31'd0, cnt_s[0] <= 32'd5}, 32'd1);
    wr("w_ctrl0", TBASE + 32'h00, 32'd0, 3'd2);
    rd(TBASE + 32'h10, a0);
    repeat (5) @(posedge HCLK);
    #1;
    rd(TBASE + 32'h10, b0);
    chk("count_frozen", b0, a0);

    // ---- PWM ----
    wr("w_duty3", TBASE + 32'h08, 32'd3, 3'd2);
    wr("w_cmp9",  TBASE + 32'h04, 32'd9, 3'd2);
    wr("w_ctrl5", TBASE + 32'h00, 32'd5, 3'd2);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm) highs++;
      @(posedge HCLK); #1;
    end
    rd(TBASE + 32'h08, v);
`ifdef AHB_TOP_PWM_EN
    chk("pwm_highs", highs, 32'd6);
    chk("duty_rb", v, 32'd3);
`else
    chk("pwm_tied0", highs, 32'd0);
    chk("duty_absent", v, 32'd0);
`endif
    wr("w_ctrl0b", TBASE + 32'h00, 32'd0, 3'd2);

    // ---- watchdog ----
    wr("w_ctrl2", TBASE + 32'h00, 32'd2, 3'd2);
    repeat (63) @(posedge HCLK);
    #1;
    chk("wd_before", {31'd0, wd_rst}, 32'd0);
    @(posedge HCLK); #1;
    chk("wd_rise", {31'd0, wd_rst}, 32'd1);
    repeat (10) @(posedge HCLK);
    #1;
    chk("wd_held", {31'd0, wd_rst}, 32'd1);
    rd(32'd1, v); chk("mem1_after_wd", v, 32'h23);

    // ---- reset pulse and synchroniser release ----
    HRESETn = 1'b0;
    #1;
    chk("rst2_wdrst", {31'd0, wd_rst}, 32'd0);
    chk("rst2_sync", {31'd0, dut.w_sync_rst}, 32'd0);
    chk_resp("rst2_resp", 32'd2);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("sync_edge1", {31'd0, dut.w_sync_rst}, 32'd0);
    @(posedge HCLK); #1;
    chk("sync_edge2", {31'd0, dut.w_sync_rst}, 32'd1);
    rd(32'd1, v); chk("mem1_cleared", v, 32'h0);
    rd(TBASE + 32'h0C, v); chk("wdload_rst2", v, 32'd64);
    chk("wd_after_rst", {31'd0, wd_rst}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
